// File: rtl/spi_frame_ctrl_pkg.sv
// Shared definitions for the SPI frame controller: FSM state type, command
// byte layout, status tag default, error counter width and small helpers.
package spi_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DRAIN
    } state_e;

    localparam int unsigned CMD_WR_BIT     = 7;
    localparam int unsigned ERR_W          = 5;
    localparam logic [2:0]  STATUS_TAG_DEF = 3'b101;

    // Error counter increments but sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] status_byte(input logic [2:0] tag,
                                               input logic [ERR_W-1:0] cnt);
        return {tag, cnt};
    endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Register-file bus between the SPI frame controller and the board registers.
//   reg_addr    : register address (write target or read address)
//   reg_wr_en   : one-clk write strobe
//   reg_wr_data : write data, valid with reg_wr_en
//   reg_rd_data : combinational read data for reg_addr
// master = controller side, slave = register file side.
interface spi_frame_ctrl_if #(
    parameter int unsigned AW = 2
);
    logic [AW-1:0] reg_addr;
    logic          reg_wr_en;
    logic [7:0]    reg_wr_data;
    logic [7:0]    reg_rd_data;

    modport master (output reg_addr, output reg_wr_en, output reg_wr_data,
                    input  reg_rd_data);
    modport slave  (input  reg_addr, input  reg_wr_en, input  reg_wr_data,
                    output reg_rd_data);
endinterface

// File: rtl/spi_frame_ctrl_shifter.sv
// SPI pin front end: synchronizes raw sclk/mosi/ss_n into clk, detects edges,
// counts bits and runs the rx/tx shift registers (mode 0, MSB first).
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   sclk_i/mosi_i/ss_n_i : raw SPI pins
//   active_i        : controller is inside a frame; bits are counted only then
//   tx_load_i/tx_byte_i : parallel load of the tx shift register
//   byte_done_o     : one-clk pulse after the 8th rise of a byte
//   rx_byte_o       : last complete received byte
//   bit_cnt_nz_o    : a partial byte is in progress
//   ss_fall_o/ss_rise_o : synchronized slave-select edges
//   miso_bit_o      : current tx MSB
module spi_sync_shifter
    import spi_frame_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       ss_n_i,
    input  logic       active_i,
    input  logic       tx_load_i,
    input  logic [7:0] tx_byte_i,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o,
    output logic       bit_cnt_nz_o,
    output logic       ss_fall_o,
    output logic       ss_rise_o,
    output logic       miso_bit_o
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic sclk_prev_q, ss_prev_q;
    logic sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, shift_en;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d, tx_shift_q, tx_shift_d;
    logic byte_done_q, byte_done_d, skip_fall_q, skip_fall_d;

    // ss_n chain resets low: a select held low through reset release produces
    // no fall, so a frame only starts after ss_n has really been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall_o = ~ss_s & ss_prev_q;
    assign ss_rise_o = ss_s & ~ss_prev_q;
    assign shift_en  = active_i & ~ss_s;

    // The fall right after a byte's 8th rise would expose the next byte's MSB;
    // the next byte is parallel-loaded before that fall instead, so it is skipped.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        byte_done_d = 1'b0;
        tx_shift_d  = tx_shift_q;
        skip_fall_d = skip_fall_q;
        if (!shift_en) begin
            bit_cnt_d   = '0;
            skip_fall_d = 1'b0;
        end else if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_done_d = 1'b1;
                rx_byte_d   = {rx_shift_q[6:0], mosi_s};
                skip_fall_d = 1'b1;
            end
        end
        if (tx_load_i) begin
            tx_shift_d = tx_byte_i;
        end else if (shift_en && sclk_fall) begin
            if (skip_fall_q) skip_fall_d = 1'b0;
            else             tx_shift_d  = {tx_shift_q[6:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            byte_done_q <= 1'b0;
            tx_shift_q  <= '1;
            skip_fall_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            byte_done_q <= byte_done_d;
            tx_shift_q  <= tx_shift_d;
            skip_fall_q <= skip_fall_d;
        end
    end

    assign byte_done_o  = byte_done_q;
    assign rx_byte_o    = rx_byte_q;
    assign bit_cnt_nz_o = |bit_cnt_q;
    assign miso_bit_o   = tx_shift_q[7];

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave transaction sequencer: frames bytes from the pins, decodes the
// command byte and drives burst writes/reads on the board register file.
// Ports:
//   clk, rst_n        : system clock (>= 8x sclk), async active-low reset
//   sclk, mosi, ss_n  : raw SPI mode-0 pins
//   miso              : slave-out data, 1 when not actively transmitting
//   busy              : frame in progress
//   frame_err         : one-clk pulse per protocol error
//   reg_bus           : register-file bus (master side)
module spi_frame_ctrl
    import spi_frame_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NREG        = 4,
    parameter logic [2:0]  STATUS_TAG  = STATUS_TAG_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic ss_n,
    output logic miso,
    output logic busy,
    output logic frame_err,
    spi_frame_ctrl_if.master reg_bus
);
    localparam int unsigned AW = $clog2(NREG);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              wr_en_q, wr_en_d, err_q, err_d, load_pend_q, load_pend_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic       byte_done, bit_cnt_nz, ss_fall, ss_rise, miso_bit, tx_load, cmd_bad, status_load;
    logic [7:0] rx_byte, tx_byte;

    spi_sync_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk_i       (sclk),
        .mosi_i       (mosi),
        .ss_n_i       (ss_n),
        .active_i     (state_q != ST_IDLE),
        .tx_load_i    (tx_load),
        .tx_byte_i    (tx_byte),
        .byte_done_o  (byte_done),
        .rx_byte_o    (rx_byte),
        .bit_cnt_nz_o (bit_cnt_nz),
        .ss_fall_o    (ss_fall),
        .ss_rise_o    (ss_rise),
        .miso_bit_o   (miso_bit)
    );

    assign cmd_bad = ((rx_byte[6:0] >> AW) != 7'd0);

    // Read data is loaded one clk after the address update so reg_rd_data
    // already reflects the new reg_addr.
    assign status_load = (state_q == ST_IDLE) && ss_fall;
    assign tx_load     = status_load || load_pend_q;
    assign tx_byte     = status_load ? status_byte(STATUS_TAG, err_cnt_q) : reg_bus.reg_rd_data;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        load_pend_d = 1'b0;
        if (wr_en_q) addr_d = addr_q + 1'b1;
        case (state_q)
            ST_IDLE:  if (ss_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (byte_done) begin
                    if (cmd_bad) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        addr_d = rx_byte[AW-1:0];
                        if (rx_byte[CMD_WR_BIT]) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d     = ST_RDATA;
                            load_pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (byte_done) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_byte;
                end
            end
            ST_RDATA: begin
                if (byte_done) begin
                    addr_d      = addr_q + 1'b1;
                    load_pend_d = 1'b1;
                end
            end
            ST_DRAIN: ;
            default:  state_d = ST_IDLE;
        endcase
        // Deselect overrides the state choice above but keeps any byte just
        // completed in the same clk (its strobe still fires next clk).
        if ((state_q != ST_IDLE) && ss_rise) begin
            state_d = ST_IDLE;
            if (bit_cnt_nz) err_d = 1'b1;
        end
        if (err_d) err_cnt_d = sat_inc(err_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            load_pend_q <= load_pend_d;
        end
    end

    assign miso = ((state_q == ST_CMD) || (state_q == ST_WDATA) || (state_q == ST_RDATA))
                  ? miso_bit : 1'b1;
    assign busy                = (state_q != ST_IDLE);
    assign frame_err           = err_q;
    assign reg_bus.reg_addr    = addr_q;
    assign reg_bus.reg_wr_en   = wr_en_q;
    assign reg_bus.reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
module tb_spi_frame_ctrl;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss_n = 1'b1;
    logic miso, busy, frame_err;

    spi_frame_ctrl_if #(.AW(AW)) rbus ();

    spi_frame_ctrl #(.SYNC_STAGES(2), .NREG(NREG), .STATUS_TAG(3'b101)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .miso      (miso),
        .busy      (busy),
        .frame_err (frame_err),
        .reg_bus   (rbus)
    );

    always #10 clk = ~clk;

    // Register file seen by the DUT, and the reference copy kept by the model.
    logic [7:0] mem     [NREG];
    logic [7:0] ref_mem [NREG];
    assign rbus.reg_rd_data = mem[rbus.reg_addr];

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int model_err = 0;
    logic [AW-1:0] wq_addr[$];
    logic [7:0]    wq_data[$];
    logic [7:0]    txb[8];
    logic [7:0]    rxb[8];

    always @(negedge clk) begin
        if (rbus.reg_wr_en) begin
            wq_addr.push_back(rbus.reg_addr);
            wq_data.push_back(rbus.reg_wr_data);
            mem[rbus.reg_addr] = rbus.reg_wr_data;
        end
        if (frame_err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of nbits SCLK periods; MISO sampled at each rise.
    task automatic xfer_bits(input logic [7:0] b, input int nbits, input int half,
                             input bit ss_early_last, output logic [7:0] r);
        logic [7:0] sh;
        sh = b;
        r  = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = sh[7];
            sh   = sh << 1;
            wait_clks(half);
            sclk = 1'b1;
            r    = {r[6:0], miso};
            if (ss_early_last && (i == nbits - 1)) begin
                wait_clks(1);
                ss_n = 1'b1;
                wait_clks(half - 1);
            end else begin
                wait_clks(half);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int extra, input int half, input bit early);
        logic [7:0] r;
        ss_n = 1'b0;
        wait_clks(half);
        for (int k = 0; k < nbytes; k++) begin
            xfer_bits(txb[k], 8, half, early && (k == nbytes - 1) && (extra == 0), r);
            rxb[k] = r;
        end
        if (extra > 0) xfer_bits(txb[nbytes], extra, half, 1'b0, r);
        if (ss_n == 1'b0) begin
            wait_clks(half);
            ss_n = 1'b1;
        end
        wait_clks(16);
    endtask

    // Reference behaviour: status = tag|min(errors,31); command bit7 selects
    // write/read, any address bit at or above NREG is a bad command; bursts
    // walk addresses modulo NREG; a trailing partial byte is one error.
    task automatic frame_and_check(input string tag, input int nbytes, input int extra,
                                   input int half, input bit early);
        logic [7:0]    cmd;
        logic [AW-1:0] a;
        logic [AW-1:0] ea[$];
        logic [7:0]    ed[$];
        int exp_pulses, start_err, n;
        cmd        = txb[0];
        start_err  = model_err;
        exp_pulses = 0;
        wq_addr.delete();
        wq_data.delete();
        err_pulses = 0;
        run_frame(nbytes, extra, half, early);
        if (nbytes >= 1) begin
            check({tag, " status"}, 32'(rxb[0]), 32'(8'hA0 + 8'(start_err > 31 ? 31 : start_err)));
            if (int'(cmd[6:0]) >= NREG) begin
                exp_pulses++;
            end else begin
                for (int k = 1; k < nbytes; k++) begin
                    a = AW'((int'(cmd[6:0]) + k - 1) % NREG);
                    if (cmd[7]) begin
                        ea.push_back(a);
                        ed.push_back(txb[k]);
                        ref_mem[a] = txb[k];
                    end else begin
                        check({tag, " rdata"}, 32'(rxb[k]), 32'(ref_mem[a]));
                    end
                end
            end
        end
        if (extra > 0) exp_pulses++;
        model_err += exp_pulses;
        check({tag, " err_pulses"}, err_pulses, exp_pulses);
        check({tag, " wr_count"}, wq_addr.size(), ea.size());
        n = (wq_addr.size() < ea.size()) ? wq_addr.size() : ea.size();
        for (int k = 0; k < n; k++) begin
            check({tag, " wr_addr"}, 32'(wq_addr[k]), 32'(ea[k]));
            check({tag, " wr_data"}, 32'(wq_data[k]), 32'(ed[k]));
        end
        check({tag, " busy_after"}, 32'(busy), 32'(0));
        check({tag, " miso_idle"}, 32'(miso), 32'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"}, 32'(miso), 32'(1));
        check({tag, " addr"}, 32'(rbus.reg_addr), 32'(0));
        check({tag, " wr_en"}, 32'(rbus.reg_wr_en), 32'(0));
        check({tag, " wr_data"}, 32'(rbus.reg_wr_data), 32'(0));
        check({tag, " busy"}, 32'(busy), 32'(0));
        check({tag, " frame_err"}, 32'(frame_err), 32'(0));
    endtask

    initial begin
        logic [7:0] r;
        int kind, len, half, extra;
        bit early;
        for (int i = 0; i < NREG; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(5);

        txb[0] = 8'h81; txb[1] = 8'h3C;
        frame_and_check("write1", 2, 0, 25, 1'b0);
        txb[0] = 8'h83; txb[1] = 8'h11; txb[2] = 8'h22;
        frame_and_check("burst_wrap", 3, 0, 25, 1'b0);

        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h5A; mem[3] = 8'h77;
        for (int i = 0; i < NREG; i++) ref_mem[i] = mem[i];
        txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h00;
        frame_and_check("read", 3, 0, 25, 1'b0);

        txb[0] = 8'h90; txb[1] = 8'h44;
        frame_and_check("bad_cmd", 2, 0, 25, 1'b0);
        txb[0] = 8'h80; txb[1] = 8'hB7;
        frame_and_check("partial", 1, 5, 25, 1'b0);
        txb[0] = 8'h82; txb[1] = 8'h6B;
        frame_and_check("same_clk", 2, 0, 4, 1'b1);
        frame_and_check("empty", 0, 0, 25, 1'b0);

        // Pin activity while deselected.
        wq_addr.delete(); err_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            wait_clks(4); sclk = 1'b1;
            wait_clks(4); sclk = 1'b0;
        end
        wait_clks(8);
        check("idle_activity wr_count", wq_addr.size(), 0);
        check("idle_activity err_pulses", err_pulses, 0);
        check("idle_activity busy", 32'(busy), 32'(0));

        // Reset in the middle of a write burst, select held low afterwards.
        ss_n = 1'b0;
        wait_clks(25);
        xfer_bits(8'h81, 8, 25, 1'b0, r);
        xfer_bits(8'h55, 4, 25, 1'b0, r);
        rst_n = 1'b0;
        wait_clks(3);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        model_err = 0;
        wq_addr.delete(); wq_data.delete(); err_pulses = 0;
        xfer_bits(8'hAA, 8, 25, 1'b0, r);
        xfer_bits(8'h55, 8, 25, 1'b0, r);
        wait_clks(10);
        check("midreset wr_count", wq_addr.size(), 0);
        check("midreset err_pulses", err_pulses, 0);
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset miso", 32'(miso), 32'(1));
        ss_n = 1'b1;
        wait_clks(20);
        txb[0] = 8'h81; txb[1] = 8'hC3;
        frame_and_check("after_reset", 2, 0, 25, 1'b0);

        for (int f = 0; f < 12; f++) begin
            kind  = int'($urandom_range(0, 2));
            len   = int'($urandom_range(1, 4));
            half  = ($urandom_range(0, 1) == 0) ? 25 : 4;
            extra = 0;
            if (kind != 2 && $urandom_range(0, 3) == 0) extra = int'($urandom_range(1, 7));
            early = (half == 4) && (extra == 0) && ($urandom_range(0, 1) == 1);
            case (kind)
                0:       txb[0] = 8'h80 | 8'($urandom_range(0, NREG - 1));
                1:       txb[0] = 8'($urandom_range(0, NREG - 1));
                default: txb[0] = 8'($urandom_range(1, 31) << 2) | 8'($urandom_range(0, 3))
                                  | (8'($urandom_range(0, 1)) << 7);
            endcase
            for (int k = 1; k < 8; k++) txb[k] = 8'($urandom);
            frame_and_check("random", len, extra, half, early);
        end

        // Drive the error counter into saturation.
        for (int f = 0; f < 34; f++) begin
            txb[0] = 8'h7F;
            frame_and_check("saturate", 1, 0, 4, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
